id_ex_stage: RTL
================

# id_ex_stage

ID/EX pipeline register and operand-select stage of the five-stage processor. Captures decoded instructions, then drives the EX-stage ALU (a bit-sliced array of one-bit ALU cells) with forwarded operands, the 3-bit operation select S and carry-in. Also detects load-use hazards and inserts bubbles.

## Interface
- WIDTH, 32, datapath width in bits
- RADDR, 5, register-specifier width; register 0 is hardwired zero
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs1, id_rs2, id_rd  in  RADDR each  source/destination specifiers
- id_rs1_data, id_rs2_data  in  WIDTH each  register-file read data
- id_imm  in  WIDTH  sign-extended immediate
- id_use_imm  in  1  B operand = immediate instead of rs2
- id_op  in  3  ALU select S
- id_reg_write, id_mem_read  in  1 each  writeback enable, instruction is a load
- stall  in  1  external hold (memory wait)
- flush  in  1  squash instruction in this stage (branch redirect)
- mem_rd  in  RADDR, mem_reg_write  in  1, mem_result  in  WIDTH  EX/MEM forwarding source
- wb_rd  in  RADDR, wb_reg_write  in  1, wb_result  in  WIDTH  MEM/WB forwarding source
- ex_valid  out  1  EX holds a valid instruction
- ex_a, ex_b  out  WIDTH each  ALU operands after forwarding/immediate select
- ex_S  out  3  ALU select
- ex_cin  out  1  carry into bit 0
- ex_rd  out  RADDR, ex_reg_write  out  1, ex_mem_read  out  1  passed downstream
- ex_store_data  out  WIDTH  forwarded rs2 value (store data)
- hazard_stall  out  1  ID/IF must hold this cycle

## Operation
- Registered state: valid, rs1, rs2, rd, rs1_data, rs2_data, imm, use_imm, op, reg_write, mem_read.
- Per-edge update priority: flush > stall > hazard_stall > load.
  - flush: valid←0, reg_write←0, mem_read←0; other fields don't-care.
  - stall (no flush): all state holds.
  - hazard_stall (no flush/stall): insert bubble (valid, reg_write, mem_read ← 0).
  - else: load all id_* fields; valid←id_valid.
- hazard_stall = valid & mem_read & rd≠0 & id_valid & (rd==id_rs1 | (!id_use_imm & rd==id_rs2)). Combinational; asserts even during stall, but takes no effect while stall or flush asserted.
- Forwarding (combinational, per operand, on registered rs1/rs2):
  - rs==0 → registered data unchanged (reads zero).
  - mem_reg_write & mem_rd==rs → mem_result (MEM wins over WB).
  - else wb_reg_write & wb_rd==rs → wb_result.
  - else registered data.
- ex_a = fwd(rs1); ex_store_data = fwd(rs2); ex_b = use_imm ? imm : fwd(rs2).
- ex_S = op. S encoding: 000 XOR, 001 XNOR, 010 ADD, 011 SUB, 100 OR, 101 NOR, 110 AND, 111 A AND NOT B.
- ex_cin = (op==3'b011): 1 only for SUB (two's-complement B invert + 1); 0 otherwise.
- ex_rd, ex_reg_write, ex_mem_read driven from registers, gated by valid (0 when valid=0).

## Timing
- Reset: all registers 0; ex_valid=0, ex_reg_write=0, ex_mem_read=0, ex_S=000, ex_cin=0, ex_rd=0, ex_a=ex_b=ex_store_data=0 (absent forwarding matches on r0: none possible), hazard_stall=0.
- Latency: ID inputs at edge N appear at EX outputs after edge N (one cycle).
- Forwarding and hazard_stall are same-cycle combinational; no extra latency.
- Load-use: exactly one bubble; ID instruction re-presented next cycle loads normally with MEM forwarding.
- rst_n low mid-pipeline: immediate bubble, no pending state survives.
- Simultaneous flush+stall: flush wins. stall with id_valid=0: still holds.

## Test plan
- Reset: rst_n low with id inputs toggling -> all outputs 0; release, ADD r3=r1(5)+r2(7) -> next cycle ex_a=5, ex_b=7, ex_S=010, ex_cin=0, ex_valid=1.
- SUB with immediate 3, rs1=10 -> ex_b=3, ex_S=011, ex_cin=1.
- Forward priority: rs1=r4, mem_rd=r4 result 0xAA, wb_rd=r4 result 0xBB -> ex_a=0xAA; drop mem_reg_write -> 0xBB; rs1=r0 with mem_rd=r0 -> ex_a=0.
- Load-use: LW r5 in EX, ID ADD using r5 -> hazard_stall=1 one cycle, EX gets bubble (ex_valid=0, ex_reg_write=0), then ADD loads.
- flush and stall together with valid instruction -> ex_valid=0 next cycle; stall alone 3 cycles -> outputs unchanged across all 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, immediate select and load-use
// bubble insertion feeding the bit-sliced EX-stage ALU.
module id_ex_stage #(
    parameter int WIDTH = 32,
    parameter int RADDR = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [RADDR-1:0] id_rs1,
    input  logic [RADDR-1:0] id_rs2,
    input  logic [RADDR-1:0] id_rd,
    input  logic [WIDTH-1:0] id_rs1_data,
    input  logic [WIDTH-1:0] id_rs2_data,
    input  logic [WIDTH-1:0] id_imm,
    input  logic             id_use_imm,
    input  logic [2:0]       id_op,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             stall,
    input  logic             flush,
    input  logic [RADDR-1:0] mem_rd,
    input  logic             mem_reg_write,
    input  logic [WIDTH-1:0] mem_result,
    input  logic [RADDR-1:0] wb_rd,
    input  logic             wb_reg_write,
    input  logic [WIDTH-1:0] wb_result,
    output logic             ex_valid,
    output logic [WIDTH-1:0] ex_a,
    output logic [WIDTH-1:0] ex_b,
    output logic [2:0]       ex_S,
    output logic             ex_cin,
    output logic [RADDR-1:0] ex_rd,
    output logic             ex_reg_write,
    output logic             ex_mem_read,
    output logic [WIDTH-1:0] ex_store_data,
    output logic             hazard_stall
);

    logic             valid_q, valid_d;
    logic [RADDR-1:0] rs1_q, rs1_d;
    logic [RADDR-1:0] rs2_q, rs2_d;
    logic [RADDR-1:0] rd_q, rd_d;
    logic [WIDTH-1:0] rs1_data_q, rs1_data_d;
    logic [WIDTH-1:0] rs2_data_q, rs2_data_d;
    logic [WIDTH-1:0] imm_q, imm_d;
    logic             use_imm_q, use_imm_d;
    logic [2:0]       op_q, op_d;
    logic             reg_write_q, reg_write_d;
    logic             mem_read_q, mem_read_d;
    logic [WIDTH-1:0] fwd_a, fwd_b;

    // A load in EX cannot forward to the instruction now in ID; hold ID one cycle.
    always_comb begin
        hazard_stall = valid_q & mem_read_q & (rd_q != '0) & id_valid &
                       ((rd_q == id_rs1) | (~id_use_imm & (rd_q == id_rs2)));
    end

    always_comb begin
        valid_d     = valid_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        rs1_data_d  = rs1_data_q;
        rs2_data_d  = rs2_data_q;
        imm_d       = imm_q;
        use_imm_d   = use_imm_q;
        op_d        = op_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        if (flush || (!stall && hazard_stall)) begin
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (!stall) begin
            valid_d     = id_valid;
            rs1_d       = id_rs1;
            rs2_d       = id_rs2;
            rd_d        = id_rd;
            rs1_data_d  = id_rs1_data;
            rs2_data_d  = id_rs2_data;
            imm_d       = id_imm;
            use_imm_d   = id_use_imm;
            op_d        = id_op;
            reg_write_d = id_reg_write;
            mem_read_d  = id_mem_read;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            rs1_data_q  <= '0;
            rs2_data_q  <= '0;
            imm_q       <= '0;
            use_imm_q   <= 1'b0;
            op_q        <= 3'b000;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            rs1_data_q  <= rs1_data_d;
            rs2_data_q  <= rs2_data_d;
            imm_q       <= imm_d;
            use_imm_q   <= use_imm_d;
            op_q        <= op_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
        end
    end

    // Younger result (EX/MEM) wins over WB; r0 is never forwarded.
    always_comb begin
        fwd_a = rs1_data_q;
        if (rs1_q != '0) begin
            if (mem_reg_write && (mem_rd == rs1_q))     fwd_a = mem_result;
            else if (wb_reg_write && (wb_rd == rs1_q))  fwd_a = wb_result;
        end
        fwd_b = rs2_data_q;
        if (rs2_q != '0) begin
            if (mem_reg_write && (mem_rd == rs2_q))     fwd_b = mem_result;
            else if (wb_reg_write && (wb_rd == rs2_q))  fwd_b = wb_result;
        end
    end

    assign ex_a          = fwd_a;
    assign ex_store_data = fwd_b;
    assign ex_b          = use_imm_q ? imm_q : fwd_b;
    assign ex_S          = op_q;
    assign ex_cin        = (op_q == 3'b011);
    assign ex_valid      = valid_q;
    assign ex_rd         = valid_q ? rd_q : '0;
    assign ex_reg_write  = valid_q & reg_write_q;
    assign ex_mem_read   = valid_q & mem_read_q;

endmodule
